// File: rtl/sum_latch_uart_tx.sv
// -----------------------------------------------------------------------------
// sum_latch_uart_tx
//   This block latches NUM_OPS operands from a shared bus. Each operand slot
//   has its own active-low strobe. When every slot holds an operand, the block
//   combines them: either a plain sum, or slot0 minus all the other slots.
//   It then sends the result as one 8N1 UART frame, LSB first.
//   Strobes that arrive while a frame is being sent are buffered in the slots
//   and feed the next frame.
//
// Ports
//   i_clk         system clock
//   i_rst         asynchronous active-high reset
//   i_data_in     shared operand bus; sampled in the latch cycle (not synchronised)
//   i_save_n      per-slot active-low strobes; asynchronous (buttons)
//   i_mode        0 = sum of all slots, 1 = slot0 minus the other slots
//   o_tx          UART serial output; idles high
//   o_tx_busy     high from CALC until the end of the stop bit
//   o_tx_done     one-cycle pulse in the last cycle of the stop bit
//   o_result      last computed result, zero-extended from RES_W bits
//   o_slot_valid  per-slot "operand held" flags
// -----------------------------------------------------------------------------
module sum_latch_uart_tx #(
  parameter int DATA_W       = 3,
  parameter int NUM_OPS      = 2,
  parameter int CLKS_PER_BIT = 868,
  parameter int SYNC_STAGES  = 2
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [DATA_W-1:0]  i_data_in,
  input  logic [NUM_OPS-1:0] i_save_n,
  input  logic               i_mode,
  output logic               o_tx,
  output logic               o_tx_busy,
  output logic               o_tx_done,
  output logic [7:0]         o_result,
  output logic [NUM_OPS-1:0] o_slot_valid
);

  localparam int RES_W = DATA_W + $clog2(NUM_OPS);
  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(CLKS_PER_BIT - 2);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CALC  = 3'd1,
    ST_START = 3'd2,
    ST_DATA  = 3'd3,
    ST_STOP  = 3'd4
  } state_t;

  // Combine all slots in RES_W bits; the arithmetic wraps naturally.
  function automatic logic [RES_W-1:0] combine_slots(
    input logic [NUM_OPS-1:0][DATA_W-1:0] slots,
    input logic                           subtract
  );
    logic [RES_W-1:0] acc;
    acc = RES_W'(slots[0]);
    for (int i = 1; i < NUM_OPS; i++) begin
      if (subtract) begin
        acc = acc - RES_W'(slots[i]);
      end else begin
        acc = acc + RES_W'(slots[i]);
      end
    end
    return acc;
  endfunction

  logic [NUM_OPS-1:0]              r_sync [SYNC_STAGES];
  logic [NUM_OPS-1:0]              r_prev;
  logic [NUM_OPS-1:0]              r_armed;
  logic [SYNC_STAGES-1:0]          r_settle;
  logic [NUM_OPS-1:0][DATA_W-1:0]  r_slot;
  logic [NUM_OPS-1:0]              r_valid;
  state_t                          r_state;
  logic [CNT_W-1:0]                r_cnt;
  logic [2:0]                      r_bit_idx;
  logic                            r_tx;
  logic                            r_tx_busy;
  logic                            r_tx_done;
  logic [7:0]                      r_result;

  logic [NUM_OPS-1:0]              w_fall;
  logic [RES_W-1:0]                w_calc;
  logic [2:0]                      w_next_idx;

  // A slot may only fire after its synchronised level has been genuinely high
  // since reset. A button held through reset release therefore never latches.
  assign w_fall     = r_armed & r_prev & ~r_sync[SYNC_STAGES-1];
  assign w_calc     = combine_slots(r_slot, i_mode);
  assign w_next_idx = r_bit_idx + 3'd1;

  // Strobe synchroniser, falling-edge history and post-reset arming.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        r_sync[s] <= '1;
      end
      r_prev   <= '1;
      r_armed  <= '0;
      r_settle <= '0;
    end else begin
      r_sync[0] <= i_save_n;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        r_sync[s] <= r_sync[s-1];
      end
      r_prev   <= r_sync[SYNC_STAGES-1];
      // r_settle marks when the last sync stage holds a sampled pin value.
      // Until then it still holds the reset value.
      r_settle <= {r_settle[SYNC_STAGES-2:0], 1'b1};
      if (r_settle[SYNC_STAGES-1]) begin
        r_armed <= r_armed | r_sync[SYNC_STAGES-1];
      end else begin
        r_armed <= r_armed;
      end
    end
  end

  // Operand slots. A strobe in the CALC cycle beats the clear.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_slot  <= '0;
      r_valid <= '0;
    end else begin
      for (int i = 0; i < NUM_OPS; i++) begin
        if (w_fall[i]) begin
          r_slot[i]  <= i_data_in;
          r_valid[i] <= 1'b1;
        end else if (r_state == ST_CALC) begin
          r_valid[i] <= 1'b0;
        end else begin
          r_valid[i] <= r_valid[i];
        end
      end
    end
  end

  // Frame sequencer with registered UART outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_bit_idx <= 3'd0;
      r_tx      <= 1'b1;
      r_tx_busy <= 1'b0;
      r_tx_done <= 1'b0;
      r_result  <= 8'd0;
    end else begin
      r_tx_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_cnt <= '0;
          if (&r_valid) begin
            r_state   <= ST_CALC;
            r_tx_busy <= 1'b1;
          end
        end
        ST_CALC: begin
          r_result <= 8'(w_calc);
          r_state  <= ST_START;
          r_tx     <= 1'b0;
          r_cnt    <= '0;
        end
        ST_START: begin
          if (r_cnt == CNT_LAST) begin
            r_cnt     <= '0;
            r_bit_idx <= 3'd0;
            r_tx      <= r_result[0];
            r_state   <= ST_DATA;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_DATA: begin
          if (r_cnt == CNT_LAST) begin
            r_cnt <= '0;
            if (r_bit_idx == 3'd7) begin
              r_tx    <= 1'b1;
              r_state <= ST_STOP;
            end else begin
              r_bit_idx <= w_next_idx;
              r_tx      <= r_result[w_next_idx];
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_STOP: begin
          if (r_cnt == CNT_LAST) begin
            r_cnt     <= '0;
            r_tx_busy <= 1'b0;
            r_state   <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
            // This registers so the pulse lands in the final stop-bit cycle.
            if (r_cnt == CNT_PRE) begin
              r_tx_done <= 1'b1;
            end
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_cnt     <= '0;
          r_tx      <= 1'b1;
          r_tx_busy <= 1'b0;
        end
      endcase
    end
  end

  assign o_tx         = r_tx;
  assign o_tx_busy    = r_tx_busy;
  assign o_tx_done    = r_tx_done;
  assign o_result     = r_result;
  assign o_slot_valid = r_valid;

endmodule

// File: tb/tb_sum_latch_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_sum_latch_uart_tx
//   Directed bench with two instances:
//   - u_dut:  DATA_W=3, NUM_OPS=2, CLKS_PER_BIT=4
//   - u_dut4: DATA_W=6, NUM_OPS=4, CLKS_PER_BIT=4
//   Expected values are computed by hand.
// -----------------------------------------------------------------------------
module tb_sum_latch_uart_tx;

  logic       clk;
  logic       rst;
  logic [2:0] data_in;
  logic [1:0] save_n;
  logic       mode;
  logic       tx, tx_busy, tx_done;
  logic [7:0] result;
  logic [1:0] slot_valid;

  logic [5:0] data4;
  logic [3:0] save4;
  logic       mode4;
  logic       tx4, busy4, done4;
  logic [7:0] result4;
  logic [3:0] valid4;

  int total = 0;
  int bad   = 0;
  int w1, w2, w3, w4;

  sum_latch_uart_tx #(.DATA_W(3), .NUM_OPS(2), .CLKS_PER_BIT(4), .SYNC_STAGES(2)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_data_in(data_in), .i_save_n(save_n), .i_mode(mode),
    .o_tx(tx), .o_tx_busy(tx_busy), .o_tx_done(tx_done), .o_result(result),
    .o_slot_valid(slot_valid)
  );

  sum_latch_uart_tx #(.DATA_W(6), .NUM_OPS(4), .CLKS_PER_BIT(4), .SYNC_STAGES(2)) u_dut4 (
    .i_clk(clk), .i_rst(rst), .i_data_in(data4), .i_save_n(save4), .i_mode(mode4),
    .o_tx(tx4), .o_tx_busy(busy4), .o_tx_done(done4), .o_result(result4),
    .o_slot_valid(valid4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Four-cycle strobe; the latch lands on the third edge.
  task automatic strobe(input int idx, input logic [2:0] val);
    data_in = val;
    save_n[idx] = 1'b0;
    repeat (4) tick();
    save_n[idx] = 1'b1;
  endtask

  // Called while in (or before) CALC; returns after the stop bit, in IDLE.
  task automatic frame_check(input logic [7:0] exp, input string tag, output int waited);
    logic [9:0] bits;
    logic [3:0] smp;
    int done_cnt;
    int done_cyc;
    bits = {1'b1, exp, 1'b0};
    waited = 0;
    while (!tx_busy && waited < 200) begin
      tick();
      waited++;
    end
    check_val($sformatf("%s_busy_rise", tag), tx_busy, 1);
    check_val($sformatf("%s_calc_tx", tag), tx, 1);
    done_cnt = 0;
    done_cyc = 0;
    if (tx_done) done_cnt++;
    tick();
    for (int b = 0; b < 10; b++) begin
      for (int c = 0; c < 4; c++) begin
        smp[c] = tx;
        if (tx_done) begin
          done_cnt++;
          done_cyc = 2 + b * 4 + c;
        end
        tick();
      end
      check_val($sformatf("%s_bit%0d", tag, b), smp, {4{bits[b]}});
    end
    check_val($sformatf("%s_done_cnt", tag), done_cnt, 1);
    check_val($sformatf("%s_done_cyc", tag), done_cyc, 41);
    check_val($sformatf("%s_busy_fall", tag), tx_busy, 0);
    check_val($sformatf("%s_result", tag), result, exp);
  endtask

  initial begin
    int done_seen;
    rst = 1'b1; data_in = 3'd0; save_n = 2'b11; mode = 1'b0;
    data4 = 6'd0; save4 = 4'b1111; mode4 = 1'b0;
    repeat (3) tick();
    check_val("rst_tx", tx, 1);
    check_val("rst_busy", tx_busy, 0);
    check_val("rst_done", tx_done, 0);
    check_val("rst_result", result, 0);
    check_val("rst_valid", slot_valid, 0);
    rst = 1'b0;
    repeat (5) tick();
    check_val("post_rst_valid", slot_valid, 0);

    // Four 63s are summed on the wide instance: no truncation, all valids clear.
    data4 = 6'd63; save4 = 4'b0000;
    repeat (3) tick();
    check_val("w4_valid_set", valid4, 4'hF);
    tick();
    check_val("w4_busy_calc", busy4, 1);
    tick();
    check_val("w4_valid_clr", valid4, 0);
    check_val("w4_result", result4, 8'hFC);
    save4 = 4'b1111;

    // Frame 1: 5 + 6 = 0x0B. First check the latch latency.
    data_in = 3'd5; save_n[0] = 1'b0;
    repeat (2) tick();
    check_val("lat_early", slot_valid, 0);
    tick();
    check_val("lat_edge", slot_valid, 2'b01);
    tick();
    save_n[0] = 1'b1;
    strobe(1, 3'd6);
    // Frame 2's operands (1 and 1) are strobed together while frame 1 is sent.
    fork
      frame_check(8'h0B, "f1", w1);
      begin
        repeat (10) tick();
        data_in = 3'd1; save_n = 2'b00;
        repeat (4) tick();
        save_n = 2'b11;
        check_val("buf_valid", slot_valid, 2'b11);
        check_val("buf_busy", tx_busy, 1);
      end
    join
    frame_check(8'h02, "f2", w2);
    check_val("idle_gap", w2, 1);

    // Difference mode: 2 - 6 wraps to 4'b1100.
    mode = 1'b1;
    strobe(0, 3'd2);
    strobe(1, 3'd6);
    frame_check(8'h0C, "f3", w3);
    mode = 1'b0;

    // A strobe on slot1 in the CALC cycle keeps slot1 valid with its new data.
    strobe(1, 3'd4);
    repeat (3) tick();
    data_in = 3'd3; save_n[0] = 1'b0;
    repeat (2) tick();
    save_n[1] = 1'b0;
    tick();
    data_in = 3'd7;
    tick();
    check_val("calc_busy", tx_busy, 1);
    check_val("calc_valid_pre", slot_valid, 2'b11);
    tick();
    check_val("calc_strobe_valid", slot_valid, 2'b10);
    check_val("calc_strobe_result", result, 8'h07);
    save_n = 2'b11;
    w4 = 0;
    while (tx_busy && w4 < 100) begin
      tick();
      w4++;
    end
    check_val("calc_frame_end", tx_busy, 0);
    strobe(0, 3'd1);
    frame_check(8'h08, "f4", w4);

    // Assert reset during the third data bit of a frame for 0x0B.
    strobe(0, 3'd5);
    strobe(1, 3'd6);
    tick();
    data_in = 3'd2; save_n[0] = 1'b0;
    repeat (4) tick();
    save_n[0] = 1'b1;
    repeat (9) tick();
    check_val("mid_tx_bit2", tx, 0);
    check_val("mid_valid", slot_valid, 2'b01);
    #2 rst = 1'b1;
    #1;
    check_val("arst_tx", tx, 1);
    check_val("arst_busy", tx_busy, 0);
    check_val("arst_valid", slot_valid, 0);
    check_val("arst_result", result, 0);
    save_n = 2'b00;
    done_seen = 0;
    repeat (3) begin
      tick();
      if (tx_done) done_seen++;
    end
    rst = 1'b0;
    repeat (8) begin
      tick();
      if (tx_done) done_seen++;
    end
    check_val("arst_no_done", done_seen, 0);
    check_val("held_no_latch", slot_valid, 0);
    check_val("held_idle", tx_busy, 0);
    save_n = 2'b11;
    repeat (4) tick();
    check_val("release_no_latch", slot_valid, 0);
    strobe(0, 3'd5);
    check_val("rearm_latch", slot_valid, 2'b01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
